// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory port, the pipeline-control inputs coming
// back from later stages, and the IF/ID register outputs.
//   master : the fetch stage (drives mem_addr and the IF/ID outputs)
//   slave  : everything around it (memory, decode, branch unit)
interface inst_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          stall;
    logic          flush;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_plus1_out;
    logic          inst_valid;
    logic          halted;

    modport master (
        output mem_addr, inst_out, pc_out, pc_plus1_out, inst_valid, halted,
        input  mem_data, stall, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, inst_out, pc_out, pc_plus1_out, inst_valid, halted,
        output mem_data, stall, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Holds the PC, reads the combinational instruction memory at the PC and
// registers {word, PC, PC+1, valid} into IF/ID. Handles stall, flush and
// redirect from later stages and parks in HALT after fetching HALT_WORD.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - inst_fetch_if.master: mem_addr/mem_data, stall, flush,
//          redirect_valid/redirect_pc, inst_out, pc_out, pc_plus1_out,
//          inst_valid, halted
module inst_fetch #(
    parameter int            AW        = 8,
    parameter int            DW        = 16,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [DW-1:0] HALT_WORD = '1
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_if.master       bus
);
    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc1;
        logic          valid;
    } ifid_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    ifid_t         ifid_q, ifid_d;

    logic [AW-1:0] pc_inc;
    logic          is_halt;

    assign pc_inc  = pc_q + AW'(1);  // wraps mod 2^AW
    assign is_halt = (bus.mem_data == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    // Priority: redirect > flush > stall > normal.
    // A bubble clears inst/valid but keeps the last pc/pc1 fields.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        if (bus.redirect_valid) begin
            // Also leaves HALT: the halt word was on the wrong path.
            pc_d         = bus.redirect_pc;
            ifid_d.inst  = '0;
            ifid_d.valid = 1'b0;
            state_d      = RUN;
        end else if (bus.flush) begin
            ifid_d.inst  = '0;
            ifid_d.valid = 1'b0;
            // Unstalled flush in RUN still advances the PC and honours halt.
            if (!bus.stall && state_q == RUN) begin
                if (is_halt) state_d = HALT;
                else         pc_d    = pc_inc;
            end
        end else if (bus.stall) begin
            // hold everything
        end else if (state_q == RUN) begin
            ifid_d.inst  = bus.mem_data;
            ifid_d.pc    = pc_q;
            ifid_d.pc1   = pc_inc;
            ifid_d.valid = 1'b1;
            if (is_halt) state_d = HALT;
            else         pc_d    = pc_inc;
        end else begin
            ifid_d.inst  = '0;
            ifid_d.valid = 1'b0;
        end
    end

    assign bus.mem_addr     = pc_q;
    assign bus.inst_out     = ifid_q.inst;
    assign bus.pc_out       = ifid_q.pc;
    assign bus.pc_plus1_out = ifid_q.pc1;
    assign bus.inst_valid   = ifid_q.valid;
    assign bus.halted       = (state_q == HALT);
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_if #(.AW(8), .DW(16)) bus ();

    inst_fetch #(.AW(8), .DW(16), .RESET_PC(8'h00), .HALT_WORD(16'hFFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [256];
    assign bus.mem_data = mem[bus.mem_addr];

    typedef struct {
        int          id;
        logic [15:0] inst;
        logic [7:0]  pc;
        logic [7:0]  pc1;
        logic        valid;
        logic        halted;
        logic [7:0]  addr;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nbad = 0;
    int   next_id = 0;

    // Monitor: the DUT presents a new IF/ID every edge; compare just after it.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            if (bus.inst_out !== e.inst || bus.pc_out !== e.pc ||
                bus.pc_plus1_out !== e.pc1 || bus.inst_valid !== e.valid ||
                bus.halted !== e.halted || bus.mem_addr !== e.addr) begin
                nbad++;
                $display("FAIL vec%0d: got inst=%h pc=%h pc1=%h v=%b h=%b addr=%h, want inst=%h pc=%h pc1=%h v=%b h=%b addr=%h",
                         e.id, bus.inst_out, bus.pc_out, bus.pc_plus1_out, bus.inst_valid,
                         bus.halted, bus.mem_addr, e.inst, e.pc, e.pc1, e.valid, e.halted, e.addr);
            end
        end
    end

    // One clock of stimulus plus the hand-computed state after the next edge.
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic rv, input logic [7:0] rpc,
                        input logic [15:0] ei, input logic [7:0] ep, input logic [7:0] ep1,
                        input logic ev, input logic eh, input logic [7:0] ea);
        exp_t e;
        @(negedge clk);
        rst                = r;
        bus.stall          = st;
        bus.flush          = fl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        e.id = next_id; e.inst = ei; e.pc = ep; e.pc1 = ep1;
        e.valid = ev; e.halted = eh; e.addr = ea;
        next_id++;
        q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222; mem[8'h02] = 16'h3333;
        mem[8'h03] = 16'h4444; mem[8'h04] = 16'h5555; mem[8'h05] = 16'h6666;
        mem[8'h06] = 16'h7777; mem[8'h07] = 16'h8888; mem[8'h40] = 16'h4040;
        mem[8'h41] = 16'h4141; mem[8'h10] = 16'hFFFF; mem[8'h20] = 16'h2020;
        mem[8'hFF] = 16'h0ABC;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;

        //   rst st fl rv rpc     inst      pc     pc1    v  h  addr
        step(1, 0, 0, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 0, 8'h00); // reset
        step(0, 0, 0, 0, 8'h00, 16'h1111, 8'h00, 8'h01, 1, 0, 8'h01);
        step(0, 0, 0, 0, 8'h00, 16'h2222, 8'h01, 8'h02, 1, 0, 8'h02);
        // stall x3 at PC=2
        step(0, 1, 0, 0, 8'h00, 16'h2222, 8'h01, 8'h02, 1, 0, 8'h02);
        step(0, 1, 0, 0, 8'h00, 16'h2222, 8'h01, 8'h02, 1, 0, 8'h02);
        step(0, 1, 0, 0, 8'h00, 16'h2222, 8'h01, 8'h02, 1, 0, 8'h02);
        step(0, 0, 0, 0, 8'h00, 16'h3333, 8'h02, 8'h03, 1, 0, 8'h03);
        step(0, 0, 0, 0, 8'h00, 16'h4444, 8'h03, 8'h04, 1, 0, 8'h04);
        step(0, 0, 0, 0, 8'h00, 16'h5555, 8'h04, 8'h05, 1, 0, 8'h05);
        // redirect wins over simultaneous stall
        step(0, 1, 0, 1, 8'h40, 16'h0000, 8'h04, 8'h05, 0, 0, 8'h40);
        step(0, 0, 0, 0, 8'h00, 16'h4040, 8'h40, 8'h41, 1, 0, 8'h41);
        // flush alone at PC=6 advances; flush+stall holds
        step(0, 0, 0, 1, 8'h06, 16'h0000, 8'h40, 8'h41, 0, 0, 8'h06);
        step(0, 0, 1, 0, 8'h00, 16'h0000, 8'h40, 8'h41, 0, 0, 8'h07);
        step(0, 1, 1, 0, 8'h00, 16'h0000, 8'h40, 8'h41, 0, 0, 8'h07);
        step(0, 0, 0, 0, 8'h00, 16'h8888, 8'h07, 8'h08, 1, 0, 8'h08);
        // PC wrap at FF
        step(0, 0, 0, 1, 8'hFF, 16'h0000, 8'h07, 8'h08, 0, 0, 8'hFF);
        step(0, 0, 0, 0, 8'h00, 16'h0ABC, 8'hFF, 8'h00, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 16'h1111, 8'h00, 8'h01, 1, 0, 8'h01);
        // halt word at 10, then redirect out of HALT
        step(0, 0, 0, 1, 8'h10, 16'h0000, 8'h00, 8'h01, 0, 0, 8'h10);
        step(0, 0, 0, 0, 8'h00, 16'hFFFF, 8'h10, 8'h11, 1, 1, 8'h10);
        step(0, 0, 0, 0, 8'h00, 16'h0000, 8'h10, 8'h11, 0, 1, 8'h10);
        step(0, 1, 0, 0, 8'h00, 16'h0000, 8'h10, 8'h11, 0, 1, 8'h10);
        step(0, 0, 1, 0, 8'h00, 16'h0000, 8'h10, 8'h11, 0, 1, 8'h10);
        step(0, 0, 0, 1, 8'h20, 16'h0000, 8'h10, 8'h11, 0, 0, 8'h20);
        step(0, 0, 0, 0, 8'h00, 16'h2020, 8'h20, 8'h21, 1, 0, 8'h21);
        // flush in RUN on the halt word still enters HALT
        step(0, 0, 0, 1, 8'h10, 16'h0000, 8'h20, 8'h21, 0, 0, 8'h10);
        step(0, 0, 1, 0, 8'h00, 16'h0000, 8'h20, 8'h21, 0, 1, 8'h10);
        step(0, 0, 0, 0, 8'h00, 16'h0000, 8'h20, 8'h21, 0, 1, 8'h10);
        // reset while halted
        step(1, 0, 0, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 16'h1111, 8'h00, 8'h01, 1, 0, 8'h01);

        // drain: bounded wait for the monitor to consume everything
        begin
            int budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (q.size() > 0) begin
                nbad++;
                $display("FAIL drain: %0d expectations left, want 0", q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage: the initiator that drives the word address into the 256x16 combinational instruction memory and consumes its read data. It holds the program counter and registers each fetched word, with its PC, into the IF/ID pipeline register. It handles pipeline stalls, flushes and branch/jump redirects from later stages, and stops at a halt word.

Parameters:
AW, 8, instruction memory word-address width; PC width
DW, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset
HALT_WORD, 16'hFFFF, instruction encoding that halts fetch

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_addr  output  AW  word address to instruction memory; equals current PC, driven combinationally from the PC register
mem_data  input  DW  instruction word from memory; combinational, valid in the same cycle as mem_addr
stall  input  1  hazard stall from decode: hold PC and IF/ID
flush  input  1  squash the IF/ID contents
redirect_valid  input  1  taken branch/jump from a later stage
redirect_pc  input  AW  target address for redirect
inst_out  output  DW  IF/ID instruction
pc_out  output  AW  IF/ID: PC of inst_out
pc_plus1_out  output  AW  IF/ID: pc_out+1 mod 2^AW, registered, for link/branch base
inst_valid  output  1  IF/ID holds a real instruction; 0 = bubble
halted  output  1  fetch FSM is in HALT

Behaviour:
- States: RUN, HALT. Reset to RUN.
- Reset (rst=1 at edge) overrides everything: PC=RESET_PC, inst_out=0, pc_out=0, pc_plus1_out=0, inst_valid=0, halted=0, state=RUN. Reset during HALT returns to RUN.
- Per-edge priority (rst excluded): redirect_valid > flush > stall > normal.
- redirect_valid=1 (any state, ignores stall): PC<=redirect_pc; IF/ID<=bubble (inst_out=0, inst_valid=0, pc_out and pc_plus1_out unchanged); state<=RUN. A redirect in HALT resumes fetch, because the halt was on the wrong path.
- flush=1, no redirect: IF/ID<=bubble; PC holds if stall=1, otherwise follows the RUN/HALT rule below.
- stall=1, no redirect, no flush: PC, IF/ID and state all hold.
- RUN normal cycle: IF/ID<={mem_data, PC, PC+1}, inst_valid<=1.
  - If mem_data!=HALT_WORD: PC<=PC+1.
  - If mem_data==HALT_WORD: PC holds and state<=HALT. The halt word itself enters IF/ID with valid=1.
- RUN with flush (not stalled): PC advances as in the normal cycle, including the halt check on mem_data. IF/ID is still a bubble.
- HALT normal cycle: PC holds, IF/ID<=bubble each cycle, halted=1.
- PC arithmetic is modulo 2^AW: 8'hFF+1 = 8'h00, with no flag. pc_plus1_out wraps the same way.
- Latency: the word at address A appears on inst_out one edge after PC==A, given no stall.
- Throughput: one instruction per cycle.
- mem_addr changes only at clock edges, never combinationally from the inputs.
- halted is a registered state decode, so it asserts the cycle after the halt word is fetched.

Test Plan:
- Reset then free run with memory[0..3]=1111,2222,3333,4444 -> after edges 1-4, inst_out=1111..4444, pc_out=0..3, inst_valid=1, mem_addr=1..4.
- Stall held for 3 cycles while PC=2 -> mem_addr stays 2, inst_out stays 2222, pc_out stays 1. On release, 3333 appears next edge.
- Redirect to 8'h40 while PC=5, with stall=1 at the same time -> next edge PC=40, inst_valid=0. Following edge inst_out=mem[40], pc_out=40.
- Flush alone at PC=6 -> inst_valid=0 next edge and PC=7. Flush+stall together -> inst_valid=0 and PC holds.
- PC=8'hFF with mem[FF]=0ABC -> inst_out=0ABC, pc_out=FF, pc_plus1_out=00, next mem_addr=00.
- mem[10]=FFFF -> IF/ID gets FFFF valid, halted=1, mem_addr stuck at 10 with bubbles. Redirect to 20 -> halted=0 and fetch resumes at 20. A separate run: rst asserted while halted -> PC=00, halted=0, inst_valid=0.
